// File: rtl/multi_issue_unit.sv
// multi_issue_unit: rotating-priority issue selector for a reservation station.
// Picks up to ISSUE_NUM ready entries per cycle, searching from a priority
// pointer that advances past the last entry granted.
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_vld_vec           per-entry ready-to-issue flags
//   i_fu_rdy            per-port functional-unit ready
//   i_flush             suppress all issue this cycle
//   o_sel_vld, o_sel    per-port grant valid and entry index (0 when not granted)
//   o_issued_vec        one-hot OR of granted entries
//   o_issue_cnt         number of grants this cycle
module multi_issue_unit #(
    parameter int unsigned ENT_NUM   = 8,
    parameter int unsigned ENT_SEL   = 3,
    parameter int unsigned ISSUE_NUM = 2
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [ENT_NUM-1:0]             i_vld_vec,
    input  logic [ISSUE_NUM-1:0]           i_fu_rdy,
    input  logic                           i_flush,
    output logic [ISSUE_NUM-1:0]           o_sel_vld,
    output logic [ISSUE_NUM*ENT_SEL-1:0]   o_sel,
    output logic [ENT_NUM-1:0]             o_issued_vec,
    output logic [1:0]                     o_issue_cnt
);

    localparam int unsigned SEL_FULL_W = 2 * ENT_SEL;

    logic [ENT_SEL-1:0]    ptr_q;
    logic [ENT_SEL-1:0]    ptr_d;

    logic [ENT_NUM-1:0]    rot_vld;
    logic                  en0;
    logic                  en1;
    logic                  c0_found;
    logic [ENT_SEL-1:0]    c0_k;
    logic                  c1_found;
    logic [ENT_SEL-1:0]    c1_k;
    logic                  g0;
    logic                  g1;
    logic [ENT_SEL-1:0]    k1;
    logic [ENT_SEL-1:0]    last_k;
    logic [ENT_SEL-1:0]    idx0;
    logic [ENT_SEL-1:0]    idx1;
    logic [1:0]            vld_full;
    logic [SEL_FULL_W-1:0] sel_full;
    logic [ENT_NUM-1:0]    issued_vec;

    // Priority pointer; only state in the block.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Port enables; reset and flush mask every grant.
    always_comb begin
        en0 = i_fu_rdy[0] & ~i_flush & ~i_rst;
        en1 = 1'b0;
        if (ISSUE_NUM == 2) begin
            en1 = i_fu_rdy[ISSUE_NUM-1] & ~i_flush & ~i_rst;
        end
    end

    // Rotate so position k of rot_vld is entry (ptr+k) mod ENT_NUM.
    always_comb begin
        rot_vld = '0;
        for (int k = 0; k < ENT_NUM; k++) begin
            rot_vld[k] = i_vld_vec[ptr_q + ENT_SEL'(k)];
        end
    end

    // First and second valid positions in priority order (descending scan, lowest wins).
    always_comb begin
        c0_found = 1'b0;
        c0_k     = '0;
        c1_found = 1'b0;
        c1_k     = '0;
        for (int k = ENT_NUM - 1; k >= 0; k--) begin
            if (rot_vld[k]) begin
                c0_found = 1'b1;
                c0_k     = ENT_SEL'(k);
            end
        end
        for (int k = ENT_NUM - 1; k >= 0; k--) begin
            if (rot_vld[k] && !(c0_found && (ENT_SEL'(k) == c0_k))) begin
                c1_found = 1'b1;
                c1_k     = ENT_SEL'(k);
            end
        end
    end

    // Grant decision and pointer advance; port 1 falls back to the first candidate when port 0 idles.
    always_comb begin
        g0     = en0 & c0_found;
        k1     = g0 ? c1_k : c0_k;
        g1     = en1 & (g0 ? c1_found : c0_found);
        last_k = g1 ? k1 : c0_k;
        idx0   = ptr_q + c0_k;
        idx1   = ptr_q + k1;
        ptr_d  = ptr_q;
        if (g0 || g1) begin
            ptr_d = ptr_q + last_k + ENT_SEL'(1);
        end
    end

    // Output assembly; ungranted ports read as zero.
    always_comb begin
        vld_full   = {g1, g0};
        sel_full   = '0;
        issued_vec = '0;
        if (g0) begin
            sel_full[0 +: ENT_SEL] = idx0;
            issued_vec[idx0]       = 1'b1;
        end
        if (g1) begin
            sel_full[ENT_SEL +: ENT_SEL] = idx1;
            issued_vec[idx1]             = 1'b1;
        end
    end

    assign o_sel_vld    = vld_full[ISSUE_NUM-1:0];
    assign o_sel        = sel_full[ISSUE_NUM*ENT_SEL-1:0];
    assign o_issued_vec = issued_vec;
    assign o_issue_cnt  = 2'(g0) + 2'(g1);

endmodule

// File: tb/tb_multi_issue_unit.sv
// Self-checking bench for multi_issue_unit (ENT_NUM=8, ISSUE_NUM=2):
// directed scenarios followed by randomized traffic against a queue-based model.
module tb_multi_issue_unit;

    logic       clk;
    logic       rst;
    logic [7:0] vld_vec;
    logic [1:0] fu_rdy;
    logic       flush;
    logic [1:0] sel_vld;
    logic [5:0] sel;
    logic [7:0] issued_vec;
    logic [1:0] issue_cnt;

    int n_checks;
    int n_errors;
    int m_ptr;

    logic [1:0] e_vld;
    logic [5:0] e_sel;
    logic [7:0] e_vec;
    logic [1:0] e_cnt;
    int         e_ptr;

    multi_issue_unit #(
        .ENT_NUM  (8),
        .ENT_SEL  (3),
        .ISSUE_NUM(2)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_vld_vec   (vld_vec),
        .i_fu_rdy    (fu_rdy),
        .i_flush     (flush),
        .o_sel_vld   (sel_vld),
        .o_sel       (sel),
        .o_issued_vec(issued_vec),
        .o_issue_cnt (issue_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: list valid entries in priority order, ready ports take from the front.
    task automatic model(input logic [7:0] vld, input logic [1:0] rdy, input logic fl,
                         input logic in_rst);
        int order[$];
        int idx;
        e_vld = '0;
        e_sel = '0;
        e_vec = '0;
        e_cnt = '0;
        e_ptr = m_ptr;
        if (fl || in_rst) return;
        for (int i = 0; i < 8; i++) begin
            idx = (m_ptr + i) % 8;
            if (vld[idx]) order.push_back(idx);
        end
        for (int p = 0; p < 2; p++) begin
            if (rdy[p] && order.size() > 0) begin
                idx              = order.pop_front();
                e_vld[p]         = 1'b1;
                e_sel[p*3 +: 3]  = 3'(idx);
                e_vec[idx]       = 1'b1;
                e_cnt            = e_cnt + 2'd1;
                e_ptr            = (idx + 1) % 8;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_vld"}, 32'(sel_vld), 32'(e_vld));
        check({tag, "_sel"}, 32'(sel), 32'(e_sel));
        check({tag, "_vec"}, 32'(issued_vec), 32'(e_vec));
        check({tag, "_cnt"}, 32'(issue_cnt), 32'(e_cnt));
    endtask

    // One clock cycle: drive just after the rising edge, check mid-cycle, advance model on the edge.
    task automatic cycle(input logic [7:0] v, input logic [1:0] r, input logic f, input string tag);
        vld_vec = v;
        fu_rdy  = r;
        flush   = f;
        #2;
        model(v, r, f, rst);
        check_all(tag);
        @(posedge clk);
        if (!rst) m_ptr = e_ptr;
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_ptr    = 0;
        rst      = 1'b1;
        vld_vec  = 8'hFF;
        fu_rdy   = 2'b11;
        flush    = 1'b0;

        // Outputs held at zero during reset even with requests pending.
        repeat (2) @(posedge clk);
        #1;
        check("rst_vld", 32'(sel_vld), 32'd0);
        check("rst_vec", 32'(issued_vec), 32'd0);
        check("rst_cnt", 32'(issue_cnt), 32'd0);
        rst = 1'b0;

        // Dual issue after reset.
        vld_vec = 8'h06; fu_rdy = 2'b11; flush = 1'b0;
        #2;
        check("dual_sel", 32'(sel), 32'h11);
        check("dual_vec", 32'(issued_vec), 32'h06);
        check("dual_cnt", 32'(issue_cnt), 32'd2);
        #1;
        m_ptr = 0;
        cycle(8'h06, 2'b11, 1'b0, "dual");
        // Wrap-around: entry 2 lowest priority from ptr 3.
        cycle(8'h07, 2'b11, 1'b0, "wrap");
        // Single port 0 from ptr 2 picks entry 7, ptr wraps to 0.
        vld_vec = 8'h81; fu_rdy = 2'b01;
        #2;
        check("p0_sel", 32'(sel), 32'd7);
        #1;
        cycle(8'h81, 2'b01, 1'b0, "p0only");
        // Single port 1 takes first valid entry.
        cycle(8'h0C, 2'b10, 1'b0, "p1only");
        // Move ptr to 5, then flush must not advance it.
        cycle(8'h10, 2'b01, 1'b0, "to5");
        cycle(8'hFF, 2'b11, 1'b1, "flush");
        check("ptr_hold", 32'(m_ptr), 32'd5);
        // First entry after the flush cycle proves ptr stayed at 5.
        vld_vec = 8'hFF; fu_rdy = 2'b11; flush = 1'b0;
        #2;
        check("post_flush_sel", 32'(sel), 32'h35);
        // Async reset mid-cycle with grants active.
        rst = 1'b1;
        #1;
        check("arst_vld", 32'(sel_vld), 32'd0);
        check("arst_sel", 32'(sel), 32'd0);
        check("arst_vec", 32'(issued_vec), 32'd0);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        m_ptr = 0;
        vld_vec = 8'h21; fu_rdy = 2'b11;
        #2;
        check("post_rst_sel", 32'(sel), 32'h28);
        #1;
        cycle(8'h21, 2'b11, 1'b0, "post_rst");

        // Randomized traffic with occasional flush, empty vectors and reset pulses.
        for (int i = 0; i < 400; i++) begin
            logic [7:0] v;
            logic [1:0] r;
            logic       f;
            v = 8'($urandom);
            if ($urandom_range(0, 9) == 0) v = 8'h00;
            else if ($urandom_range(0, 3) == 0) v = 8'(1 << $urandom_range(0, 7));
            r = 2'($urandom);
            f = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 49) == 0) begin
                rst = 1'b1;
                #1;
                check("rnd_rst_cnt", 32'(issue_cnt), 32'd0);
                @(posedge clk);
                #1;
                rst   = 1'b0;
                m_ptr = 0;
            end
            cycle(v, r, f, "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/multi_issue_unit.md
MULTI_ISSUE_UNIT -- requirements
Module: multi_issue_unit

Interface
REQ-001 SHALL have parameter ENT_NUM, default 8: number of reservation-station entries; power of two, at least 2.
REQ-002 SHALL have parameter ENT_SEL, default 3: entry index width; equals log2(ENT_NUM).
REQ-003 SHALL have parameter ISSUE_NUM, default 2: number of issue ports; legal values 1 or 2.
REQ-004 SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port i_rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port i_vld_vec, input, ENT_NUM bits: entry n is ready to issue when bit n is 1.
REQ-007 SHALL have port i_fu_rdy, input, ISSUE_NUM bits: port p's functional unit accepts an instruction this cycle when bit p is 1.
REQ-008 SHALL have port i_flush, input, 1 bit: pipeline flush; suppresses all issue in the current cycle.
REQ-009 SHALL have port o_sel_vld, output, ISSUE_NUM bits: port p issues this cycle when bit p is 1.
REQ-010 SHALL have port o_sel, output, ISSUE_NUM*ENT_SEL bits: bits [p*ENT_SEL +: ENT_SEL] hold the entry index for port p; meaningful only when o_sel_vld[p]=1, otherwise 0.
REQ-011 SHALL have port o_issued_vec, output, ENT_NUM bits: one bit per entry issued this cycle, used by the reservation station to clear those entries.
REQ-012 SHALL have port o_issue_cnt, output, 2 bits: number of instructions issued this cycle (0 to ISSUE_NUM).

Function
REQ-013 SHALL hold one ENT_SEL-bit priority pointer register, ptr; this is the only sequential state.
REQ-014 SHALL search entries in priority order ptr, ptr+1, …, ptr+ENT_NUM-1, with indices taken mod ENT_NUM.
REQ-015 SHALL grant port 0, when i_fu_rdy[0]=1, the first valid entry in priority order.
REQ-016 SHALL grant port 1, when ISSUE_NUM=2 and i_fu_rdy[1]=1, the first valid entry in priority order not already granted to port 0.
- If port 0 is not ready or has no grant, port 1 takes the first valid entry.
REQ-017 SHALL never grant the same entry to two ports, and each port SHALL receive at most one grant per cycle.
REQ-018 SHALL drive all outputs combinationally from inputs and ptr in the same cycle (zero-cycle issue latency).
REQ-019 SHALL force o_sel_vld=0, o_sel=0, o_issued_vec=0 and o_issue_cnt=0 when i_vld_vec=0, when all i_fu_rdy bits are 0, or when i_flush=1.
REQ-020 SHALL hold ptr unchanged on any cycle with no grant, including flush cycles.
REQ-021 SHALL, on any grant, load ptr with (index of the last granted entry in priority order + 1) mod ENT_NUM on the next rising edge of i_clk.
- Wrap-around from ENT_NUM-1 to 0 is natural binary overflow.
REQ-022 SHALL make o_issued_vec equal to the OR of the one-hot encodings of all granted indices, and o_issue_cnt equal to the popcount of o_sel_vld.
REQ-023 SHALL NOT use i_vld_vec of any previous cycle; clearing issued entries is the reservation station's responsibility.

Reset
REQ-024 SHALL set ptr to 0 immediately when i_rst is asserted, independent of i_clk.
REQ-025 SHALL force all outputs to 0 while i_rst=1, including assertion in the middle of operation.
REQ-026 SHALL, on the first cycle after i_rst deasserts, resume normal operation with ptr=0.

Verification (ENT_NUM=8, ISSUE_NUM=2)
REQ-027 SHALL cover dual issue after reset.
- Stimulus: after reset, i_vld_vec=8'h06, i_fu_rdy=2'b11.
- Response: o_sel_vld=2'b11, sel0=1, sel1=2, o_issued_vec=8'h06, o_issue_cnt=2; ptr=3 next cycle.
REQ-028 SHALL cover wrap-around.
- Stimulus: ptr=3, i_vld_vec=8'h07, i_fu_rdy=2'b11.
- Response: sel0=0, sel1=1 (entry 2 is lowest priority), o_issued_vec=8'h03; ptr=2 next cycle.
REQ-029 SHALL cover a single ready port 0.
- Stimulus: ptr=2, i_vld_vec=8'h81, i_fu_rdy=2'b01.
- Response: o_sel_vld=2'b01, sel0=7, sel1=0, o_issue_cnt=1; ptr=0 next cycle.
REQ-030 SHALL cover a single ready port 1.
- Stimulus: ptr=0, i_vld_vec=8'h0C, i_fu_rdy=2'b10.
- Response: o_sel_vld=2'b10, sel1=2, o_issued_vec=8'h04; ptr=3 next cycle.
REQ-031 SHALL cover flush.
- Stimulus: ptr=5, i_vld_vec=8'hFF, i_fu_rdy=2'b11, i_flush=1.
- Response: all outputs 0; ptr stays 5.
REQ-032 SHALL cover asynchronous reset mid-operation.
- Stimulus: i_rst asserted between clock edges while ptr=5 and grants are active.
- Response: outputs drop to 0 immediately; after release with i_vld_vec=8'h21 and i_fu_rdy=2'b11, sel0=0 and sel1=5.
